// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode front end.
//   XLEN       : data/address width of queued fields
//   NOP_INSTR  : instruction word shown to decode when no entry is valid
//   fq_entry_t : one fetch queue entry {pc, pc_plus4, instr}
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_mem.sv
// Fetch queue storage: DEPTH x fq_entry_t register array.
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write slot
//   wdata : entry written at waddr
//   raddr : read slot
//   rdata : entry at raddr (combinational)
// Contents are deliberately not reset; occupancy is tracked by the owner.
module fq_mem
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fq_entry_t                rdata
);

    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   valid_f, pc_f, pc_plus4_f,
//   instr_f                     : fetched entry offered by fetch
//   stall_f                     : queue full, stalls the fetch PC register
//   flush                       : redirect from execute, empties the queue
//   valid_d, ready_d            : head handshake with decode
//   pc_d, pc_plus4_d, instr_d   : head entry (zeros / NOP when empty)
//   count                       : number of occupied entries
// WIDTH must equal riscv_pkg::XLEN, as entries use the shared struct.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_f,
    input  logic [WIDTH-1:0]           pc_f,
    input  logic [WIDTH-1:0]           pc_plus4_f,
    input  logic [WIDTH-1:0]           instr_f,
    output logic                       stall_f,
    input  logic                       flush,
    output logic                       valid_d,
    input  logic                       ready_d,
    output logic [WIDTH-1:0]           pc_d,
    output logic [WIDTH-1:0]           pc_plus4_d,
    output logic [WIDTH-1:0]           instr_d,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    fq_entry_t     wr_entry, rd_entry;

    // Status is decoded from registered count only, so a same-cycle pop
    // never frees a slot for a push and ready_d/flush never reach stall_f.
    assign stall_f = (count_q == CW'(DEPTH));
    assign valid_d = (count_q != '0);
    assign count   = count_q;

    assign push = valid_f && !stall_f && !flush;
    assign pop  = valid_d && ready_d && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        wr_entry          = '0;
        wr_entry.pc       = pc_f;
        wr_entry.pc_plus4 = pc_plus4_f;
        wr_entry.instr    = instr_f;
    end

    fq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    always_comb begin
        pc_d       = '0;
        pc_plus4_d = '0;
        instr_d    = WIDTH'(NOP_INSTR);
        if (valid_d) begin
            pc_d       = rd_entry.pc;
            pc_plus4_d = rd_entry.pc_plus4;
            instr_d    = rd_entry.instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_f;
    logic [31:0] pc_f, pc_plus4_f, instr_f;
    logic        stall_f;
    logic        flush;
    logic        valid_d;
    logic        ready_d;
    logic [31:0] pc_d, pc_plus4_d, instr_d;
    logic [2:0]  count;

    int   checks = 0;
    int   fails  = 0;
    int   mcount = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_f    (valid_f),
        .pc_f       (pc_f),
        .pc_plus4_f (pc_plus4_f),
        .instr_f    (instr_f),
        .stall_f    (stall_f),
        .flush      (flush),
        .valid_d    (valid_d),
        .ready_d    (ready_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .instr_d    (instr_d),
        .count      (count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h00500093 + pc;
    endfunction

    // Monitor: on every accepted handshake, the head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && valid_d && ready_d && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", pc_d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("head_pc", pc_d, e.pc);
                chk("head_pc4", pc_plus4_d, e.pc4);
                chk("head_instr", instr_d, e.instr);
            end
        end
    end

    // One clock cycle of stimulus with status checks against the bench model count.
    task automatic cyc(input bit vf, input logic [31:0] pc, input bit rdy, input bit fl);
        bit acc_push, acc_pop;
        @(posedge clk);
        #1;
        valid_f    = vf;
        pc_f       = pc;
        pc_plus4_f = pc + 32'd4;
        instr_f    = instr_of(pc);
        ready_d    = rdy;
        flush      = fl;
        acc_push = vf && (mcount < DEPTH) && !fl;
        acc_pop  = (mcount != 0) && rdy && !fl;
        if (acc_push) sb.push_back('{pc, pc + 32'd4, instr_of(pc)});
        if (fl) sb.delete();
        @(negedge clk);
        chk("count", 32'(count), 32'(mcount));
        chk("stall_f", 32'(stall_f), 32'(mcount == DEPTH));
        chk("valid_d", 32'(valid_d), 32'(mcount != 0));
        if (mcount == 0) begin
            chk("empty_instr", instr_d, NOP);
            chk("empty_pc", pc_d, 32'h0);
        end
        if (fl) mcount = 0;
        else mcount = mcount + int'(acc_push) - int'(acc_pop);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; valid_f = 1'b0; pc_f = '0; pc_plus4_f = '0; instr_f = '0;
        ready_d = 1'b0; flush = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_d), 32'h0);
        chk("rst_stall", 32'(stall_f), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc", pc_d, 32'h0);
        chk("rst_pc4", pc_plus4_d, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, fifth push refused, then drain in order.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming with decode always ready: count settles at 1, pointers wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i * 4), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous push/pop at count 2, then at full.
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 1'b1, 1'b0);
        cyc(1'b1, 32'h20C, 1'b1, 1'b0);
        cyc(1'b1, 32'h210, 1'b0, 1'b0);
        cyc(1'b1, 32'h214, 1'b0, 1'b0);
        cyc(1'b1, 32'h218, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a concurrent push; the next push becomes head a cycle later.
        cyc(1'b1, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 1'b0, 1'b0);
        cyc(1'b1, 32'h308, 1'b0, 1'b0);
        cyc(1'b1, 32'h040, 1'b1, 1'b1);
        cyc(1'b1, 32'h080, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_head_pc4", pc_plus4_d, 32'h84);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Empty pops do not underflow.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h400, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream at count 3.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h500 + i * 4), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        valid_f = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_valid", 32'(valid_d), 32'h0);
        chk("mid_rst_instr", instr_d, NOP);
        chk("mid_rst_stall", 32'(stall_f), 32'h0);
        sb.delete();
        mcount = 0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 32'h600, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        chk("sb_residual", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Captures each fetched {pc, pc+4, instruction} triple into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. It back-pressures fetch through a stall output and is flushed on a taken branch or jump from execute. Fetch and decode can therefore stall independently without losing or duplicating instructions.

## Interface
- WIDTH, 32, data and address width
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- valid_f  in  1  fetch presents a valid instruction this cycle
- pc_f  in  WIDTH  PC of the fetched instruction
- pc_plus4_f  in  WIDTH  PC+4 of the fetched instruction
- instr_f  in  WIDTH  fetched instruction word
- stall_f  out  1  queue full; drives the fetch PC register stall
- flush  in  1  redirect from execute (pc_src_e); discard all queued and incoming entries
- valid_d  out  1  head entry valid for decode
- ready_d  in  1  decode accepts the head entry this cycle
- pc_d  out  WIDTH  head PC
- pc_plus4_d  out  WIDTH  head PC+4
- instr_d  out  WIDTH  head instruction
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- State: storage array of DEPTH entries, write pointer wr_ptr and read pointer rd_ptr (each $clog2(DEPTH) bits, natural wrap), and count.
- push = valid_f && !stall_f && !flush. The entry is written at wr_ptr, then wr_ptr increments.
- pop = valid_d && ready_d && !flush. rd_ptr increments.
- count next value: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- stall_f = (count == DEPTH). It is decoded from the registered count only. A pop in the same cycle does not free a slot for a push that cycle.
- valid_d = (count != 0).
- When valid_d is 1, pc_d, pc_plus4_d and instr_d show the head entry (combinational read at rd_ptr).
- When valid_d is 0, instr_d = NOP (0x00000013), and pc_d and pc_plus4_d are 0.
- There is no bypass. An entry pushed into an empty queue is visible to decode the following cycle.
- Flush takes priority over everything else:
  - wr_ptr, rd_ptr and count go to 0.
  - A simultaneous push is dropped and a simultaneous pop is not counted.
  - valid_d is 0 on the next cycle.
  - Flush on an empty queue is harmless.
- Decode must treat the head entry as consumed only on a cycle where valid_d && ready_d && !flush.
- Reset (rst low, at any time including mid-operation) clears the pointers and count asynchronously. Storage contents are not reset.

## Timing
- Reset values:
  - valid_d = 0, stall_f = 0, count = 0
  - instr_d = 0x00000013, pc_d = 0, pc_plus4_d = 0
- Latency: a push at edge N makes the entry visible at the decode outputs after edge N, i.e. in cycle N+1.
- Throughput: with ready_d held at 1, one instruction per cycle, steady state count = 1.
- Full boundary: count reaches DEPTH, then stall_f = 1 from the next cycle. stall_f drops in the cycle after the first pop.
- Wrap: the pointers wrap from DEPTH-1 to 0 with no bubble.
- No combinational path from ready_d or flush to stall_f.
- Paths from ready_d to any output: none.
- Path from flush to outputs: none. The effect appears after the clock edge.

## Structure
- Shared package riscv_pkg:
  - NOP_INSTR constant (32'h00000013)
  - packed struct fq_entry_t {pc, pc_plus4, instr} sized by WIDTH
- One sub-module, fq_mem: DEPTH x fq_entry_t register array with one synchronous write port and one combinational read port.
- Pointer, count and flush control live in fetch_queue itself.

## Test plan
- Reset mid-stream with count = 3: drive rst low → count = 0 and valid_d = 0 immediately; instr_d = 0x00000013, stall_f = 0.
- Fill, DEPTH = 4, ready_d = 0: push pc 0x0, 0x4, 0x8, 0xC → count = 4 and stall_f = 1. A fifth push with pc 0x10 is ignored; after draining, pc_d shows 0x0, 0x4, 0x8, 0xC in order.
- Streaming with ready_d = 1: push 8 consecutive PCs from 0x0 → each appears at pc_d exactly one cycle after its push, count stays 1, and the pointers wrap with no gap.
- Simultaneous push and pop at count = 2 → count stays 2, order is preserved. The same at count = 4: the pop succeeds, the push is refused, and count = 3.
- Flush with count = 3 plus a concurrent push of pc 0x40 → next cycle count = 0 and valid_d = 0. The next push of pc 0x80 is the head one cycle later, with pc_plus4_d = 0x84.
- Empty pop: ready_d = 1 and valid_f = 0 for 3 cycles → count stays 0, there is no pointer underflow, and instr_d stays 0x00000013.
